// File: rtl/svga_pkg.sv
// Shared types and default geometry for the SVGA blitter.
package svga_pkg;

  localparam int FB_STRIDE = 100;
  localparam int FB_HEIGHT = 75;
  localparam int FB_ADDR_W = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } blit_state_e;

  typedef struct packed {
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] w;
    logic [7:0] h;
    logic [7:0] color;
  } blit_cmd_t;

endpackage

// File: rtl/svga_blit_lane_mask.sv
// Byte-lane enable generator: from the start lane and bytes remaining in the row,
// produces the write mask for one 32-bit word and the number of bytes it covers.
module svga_blit_lane_mask (
  input  logic [1:0] lane_lo,
  input  logic [7:0] bytes_left,
  output logic [3:0] wmask,
  output logic [2:0] n
);

  logic [2:0] room;

  always_comb begin
    room  = 3'd4 - {1'b0, lane_lo};
    n     = (bytes_left < {5'd0, room}) ? bytes_left[2:0] : room;
    wmask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      wmask[i] = (3'(i) >= {1'b0, lane_lo}) && (3'(i) < ({1'b0, lane_lo} + n));
    end
  end

endmodule

// File: rtl/svga_blit_fill.sv
// Rectangle-fill engine emitting masked 32-bit writes toward the framebuffer.
// Optional screen clipping is built when SVGA_BLIT_CLIP_EN is defined.
module svga_blit_fill
  import svga_pkg::*;
#(
  parameter int FB_START = 0,
  parameter int STRIDE   = FB_STRIDE,
  parameter int HEIGHT   = FB_HEIGHT,
  parameter int ADDR_W   = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        x0,
  input  logic [7:0]        y0,
  input  logic [7:0]        w,
  input  logic [7:0]        h,
  input  logic [7:0]        color,
  output logic              blt_req,
  input  logic              blt_gnt,
  output logic [31:0]       blt_addr,
  output logic [31:0]       blt_wdata,
  output logic [3:0]        blt_wmask,
  output logic              busy,
  output logic              done,
  output blit_state_e       dbg_state
);

  // Handshake: blt_req with addr/wdata/wmask is held unchanged until a cycle
  // with blt_req && blt_gnt; that cycle is the transfer, and only reset cancels it.

  blit_state_e         state;
  blit_cmd_t           cmd;
  logic [ADDR_W-1:0]   row_addr;
  logic [ADDR_W-1:0]   cur_addr;
  logic [7:0]          x_left;
  logic [7:0]          rows_left;
  logic [7:0]          w_eff_q;
  logic [2:0]          cur_n;

  logic [7:0]          w_eff;
  logic [7:0]          h_eff;
  logic [ADDR_W-1:0]   start_addr;
  logic [ADDR_W-1:0]   post_a;
  logic [ADDR_W-1:0]   next_row;
  logic [7:0]          post_left;
  logic                row_end;
  logic                xfer;
  logic [ADDR_W-1:0]   nxt_a;
  logic [7:0]          nxt_left;
  logic [3:0]          lm_wmask;
  logic [2:0]          lm_n;

  assign dbg_state = state;

`ifdef SVGA_BLIT_CLIP_EN
  always_comb begin
    w_eff = 8'd0;
    h_eff = 8'd0;
    if ((int'(cmd.x0) < STRIDE) && (int'(cmd.y0) < HEIGHT)) begin
      w_eff = (int'(cmd.w) < (STRIDE - int'(cmd.x0))) ? cmd.w : 8'(STRIDE - int'(cmd.x0));
      h_eff = (int'(cmd.h) < (HEIGHT - int'(cmd.y0))) ? cmd.h : 8'(HEIGHT - int'(cmd.y0));
    end
  end
`else
  // Unclipped: long rows simply run on into the next row's bytes.
  logic unused_height;
  assign unused_height = (HEIGHT > 0);
  assign w_eff = cmd.w;
  assign h_eff = cmd.h;
`endif

  // The only multiply; used in SETUP alone.
  assign start_addr = ADDR_W'(FB_START + int'(cmd.y0) * STRIDE + int'(cmd.x0));
  assign post_a     = cur_addr + ADDR_W'(cur_n);
  assign post_left  = x_left - {5'd0, cur_n};
  assign row_end    = (post_left == 8'd0);
  assign next_row   = row_addr + ADDR_W'(STRIDE);
  assign xfer       = (state == RUN) && blt_req && blt_gnt;

  // Address/remaining count of the write that will be presented next.
  always_comb begin
    nxt_a    = start_addr;
    nxt_left = w_eff;
    if (state == RUN) begin
      if (row_end) begin
        nxt_a    = next_row;
        nxt_left = w_eff_q;
      end else begin
        nxt_a    = post_a;
        nxt_left = post_left;
      end
    end
  end

  svga_blit_lane_mask u_lane_mask (
    .lane_lo    (nxt_a[1:0]),
    .bytes_left (nxt_left),
    .wmask      (lm_wmask),
    .n          (lm_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd       <= '0;
      row_addr  <= '0;
      cur_addr  <= '0;
      x_left    <= 8'd0;
      rows_left <= 8'd0;
      w_eff_q   <= 8'd0;
      cur_n     <= 3'd0;
      blt_req   <= 1'b0;
      blt_addr  <= 32'd0;
      blt_wdata <= 32'd0;
      blt_wmask <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cmd   <= '{x0: x0, y0: y0, w: w, h: h, color: color};
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          blt_wdata <= {4{cmd.color}};
          w_eff_q   <= w_eff;
          rows_left <= h_eff;
          row_addr  <= start_addr;
          if ((w_eff == 8'd0) || (h_eff == 8'd0)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            blt_req   <= 1'b1;
            cur_addr  <= nxt_a;
            x_left    <= nxt_left;
            cur_n     <= lm_n;
            blt_wmask <= lm_wmask;
            blt_addr  <= 32'({nxt_a[ADDR_W-1:2], 2'b00});
            state     <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            if (row_end && (rows_left == 8'd1)) begin
              blt_req <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              if (row_end) begin
                row_addr  <= next_row;
                rows_left <= rows_left - 8'd1;
              end
              cur_addr  <= nxt_a;
              x_left    <= nxt_left;
              cur_n     <= lm_n;
              blt_wmask <= lm_wmask;
              blt_addr  <= 32'({nxt_a[ADDR_W-1:2], 2'b00});
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
